// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions.
//   state_t   : controller states of inv_key_expansion
//   dir_t     : direction of one key-schedule step
//   NR        : number of AES-128 rounds
//   rcon()    : round constant word, constant byte in [31:24]
//   rot_word(): cyclic byte rotation [a0,a1,a2,a3] -> [a1,a2,a3,a0]
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE,
    DONE
  } state_t;

  typedef enum logic {
    DIR_FWD,
    DIR_BWD
  } dir_t;

  function automatic logic [31:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_expansion_key_round_step.sv
// One AES-128 key-schedule step, forward or backward, combinational.
// The S-box lookup is done outside so one set of S-boxes can be shared:
// this block emits the word to substitute and consumes the result.
//   key       : current round key, w0 in [127:96]
//   round     : round r of the step (fwd: r-1 -> r, bwd: r -> r-1)
//   dir       : DIR_FWD or DIR_BWD
//   sub_word  : SubWord(sbox_word), returned by the S-boxes
//   next_key  : resulting round key
//   sbox_word : RotWord of the word needing substitution
module key_round_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   round,
  input  dir_t         dir,
  input  logic [31:0]  sub_word,
  output logic [127:0] next_key,
  output logic [31:0]  sbox_word
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;

  assign {k0, k1, k2, k3} = key;

  assign n0 = k0 ^ sub_word ^ rcon(round);
  assign n1 = k1 ^ n0;
  assign n2 = k2 ^ n1;
  assign n3 = k3 ^ n2;

  // Backward step recovers the previous last word first (k3 ^ k2), since
  // the previous w0 depends on SubWord of it.
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;
  assign p0 = k0 ^ sub_word ^ rcon(round);

  always_comb begin
    if (dir == DIR_BWD) begin
      sbox_word = rot_word(p3);
      next_key  = {p0, p1, p2, p3};
    end else begin
      sbox_word = rot_word(k3);
      next_key  = {n0, n1, n2, n3};
    end
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box, pure combinational table lookup.
//   value : input byte
//   subst : substituted byte
module sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  localparam logic [0:255][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = TABLE[value];

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 decrypt round-key generator. On start the cipher key is expanded
// forward to round NR (one round per cycle), then round keys NR..0 are
// streamed over a valid/ready handshake, rolling the schedule backward one
// round per accepted key. Only one round key is stored.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a schedule (sampled in IDLE only)
//   init_key    : cipher key, w0 in [127:96]
//   round_key   : current round key, word 4r in [127:96]
//   round_index : round number of round_key
//   key_valid   : round_key/round_index valid
//   key_ready   : consumer accepts the key this cycle
//   busy        : high outside IDLE
//   done        : one-cycle pulse after round 0 is accepted
module inv_key_expansion
  import aes_pkg::*;
#(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] init_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_index,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       state, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   rnd, rnd_next;
  dir_t         dir;
  logic [127:0] step_key;
  logic [31:0]  sbox_in, sbox_out;

  // Kept out of the next-state process so the step datapath is not seen as
  // a combinational loop through that process.
  assign dir = (state == SERVE) ? DIR_BWD : DIR_FWD;

  key_round_step u_step (
    .key      (key_reg),
    .round    (rnd),
    .dir      (dir),
    .sub_word (sbox_out),
    .next_key (step_key),
    .sbox_word(sbox_in)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .value(sbox_in[i*8 +: 8]),
      .subst(sbox_out[i*8 +: 8])
    );
  end

  always_comb begin
    state_next = state;
    key_next   = key_reg;
    rnd_next   = rnd;
    case (state)
      IDLE: begin
        if (start) begin
          key_next   = init_key;
          rnd_next   = 4'd1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        key_next = step_key;
        if (rnd == LAST_ROUND) begin
          state_next = SERVE;
        end else begin
          rnd_next = rnd + 4'd1;
        end
      end
      SERVE: begin
        if (key_ready) begin
          if (rnd == 4'd0) begin
            state_next = DONE;
          end else begin
            key_next = step_key;
            rnd_next = rnd - 4'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      key_reg <= '0;
      rnd     <= '0;
    end else begin
      state   <= state_next;
      key_reg <= key_next;
      rnd     <= rnd_next;
    end
  end

  assign round_key   = key_reg;
  assign round_index = rnd;
  assign key_valid   = (state == SERVE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_inv_key_expansion.sv
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] init_key;
  logic [127:0] round_key;
  logic [3:0]   round_index;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  inv_key_expansion #(.NR(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .init_key   (init_key),
    .round_key  (round_key),
    .round_index(round_index),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- behavioural model: plain FIPS-197 expansion ----------
  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk   [11];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- compare process --------------------------------------
  logic         active = 1'b0;
  int           exp_r = 10;
  int           hs_count = 0;
  logic         expect_done = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;

  always @(negedge clk) begin
    if (!reset && active) begin
      if (expect_done) begin
        check("done_pulse", 128'(done), 128'(1'b1));
        check("valid_low_in_done", 128'(key_valid), 128'(1'b0));
        expect_done = 1'b0;
      end else begin
        check("no_spurious_done", 128'(done), 128'(1'b0));
      end
      if (prev_stall) begin
        check("stall_key_stable", round_key, prev_key);
        check("stall_idx_stable", 128'(round_index), 128'(prev_idx));
        check("stall_valid_held", 128'(key_valid), 128'(1'b1));
      end
      prev_stall = key_valid && !key_ready;
      prev_key   = round_key;
      prev_idx   = round_index;
      if (key_valid) begin
        check("round_index", 128'(round_index), 128'(exp_r));
        check("round_key", round_key, exp_rk[exp_r]);
        if (key_ready) begin
          hs_count++;
          if (exp_r == 0) expect_done = 1'b1;
          else exp_r--;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- key_ready driver -------------------------------------
  int ready_mode = 0;   // 0: always ready, 1: random, 2: stall 5 cycles at r=9
  int stall_left = 0;

  initial begin
    key_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: key_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (key_valid && round_index == 4'd9 && stall_left > 0) begin
            key_ready = 1'b0;
            stall_left--;
          end else begin
            key_ready = 1'b1;
          end
        end
        default: key_ready = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus tasks ---------------------------------------
  task automatic start_run(input logic [127:0] key, input bit inject_expand);
    int n;
    build_model(key);
    exp_r       = 10;
    hs_count    = 0;
    expect_done = 1'b0;
    @(posedge clk);
    #1;
    init_key = key;
    start    = 1'b1;
    active   = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (inject_expand && n == 4) begin
        start    = 1'b1;
        init_key = {$urandom, $urandom, $urandom, $urandom};
      end
      if (key_valid) break;
    end
    start = 1'b0;
    check("valid_latency", 128'(n), 128'(11));
    if (inject_expand) begin
      start    = 1'b1;
      init_key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic finish_run(input bit start_in_done);
    int n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check("done_seen", 128'(done), 128'(1'b1));
    if (start_in_done) begin
      start    = 1'b1;
      init_key = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    active = 1'b0;
    check("handshakes_per_run", 128'(hs_count), 128'(11));
    check("idle_busy_low", 128'(busy), 128'(1'b0));
    check("idle_key_held", round_key, exp_rk[0]);
    check("idle_idx_held", 128'(round_index), 128'(0));
    if (start_in_done) begin
      @(posedge clk);
      #1;
      check("start_in_done_ignored", 128'(busy), 128'(1'b0));
    end
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    init_key = '0;
    build_sbox();
    check("model_sbox_00", 128'(sbox_tab[8'h00]), 128'(8'h63));
    check("model_sbox_53", 128'(sbox_tab[8'h53]), 128'(8'hed));
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 128'(key_valid), 128'(1'b0));
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_done", 128'(done), 128'(1'b0));
    check("reset_key", round_key, 128'h0);
    check("reset_idx", 128'(round_index), 128'(0));
    reset = 1'b0;

    // FIPS-197 A.1 key at full throughput
    ready_mode = 0;
    start_run(FIPS_KEY, 1'b0);
    check("model_a1_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_a1_r9", exp_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("model_a1_r0", exp_rk[0], FIPS_KEY);
    finish_run(1'b0);

    // Consumer stall at r=9
    ready_mode = 2;
    stall_left = 5;
    start_run(FIPS_KEY, 1'b0);
    finish_run(1'b0);
    check("stall_consumed", 128'(stall_left), 128'(0));

    // start pulses in EXPAND, SERVE and DONE are ignored; then a fresh run
    ready_mode = 0;
    start_run(FIPS_KEY, 1'b1);
    finish_run(1'b1);
    start_run({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    finish_run(1'b0);

    // Random keys, random back-pressure
    ready_mode = 1;
    for (int k = 0; k < 20; k++) begin
      start_run({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      finish_run(1'b0);
    end

    // All-zero key
    ready_mode = 0;
    start_run(128'h0, 1'b0);
    check("model_zero_r10", exp_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("model_zero_r1", exp_rk[1], 128'h62636363626363636263636362636363);
    finish_run(1'b0);

    // Asynchronous reset mid-SERVE at r=6
    ready_mode = 0;
    start_run(FIPS_KEY, 1'b0);
    begin
      int n = 0;
      while (n < 100) begin
        if (key_valid && round_index == 4'd6) break;
        @(posedge clk);
        #1;
        n++;
      end
      check("reached_r6", 128'(round_index), 128'(6));
    end
    active = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 128'(key_valid), 128'(1'b0));
    check("async_rst_busy", 128'(busy), 128'(1'b0));
    check("async_rst_done", 128'(done), 128'(1'b0));
    check("async_rst_idx", 128'(round_index), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_idle", 128'(busy), 128'(1'b0));
    start_run(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    check("model_seq_r10", exp_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    finish_run(1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
